// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufz_rx.sv
// Load-end receiver for bufz tri-state segments: sync EN/BUS, wait for SETTLE stable samples, capture one word per window.
// Latency: Q/VLD update on edge SYNC_STAGES+SETTLE+1 after EN/BUS change; ACK clears VLD on the next edge.
// No backpressure: capturing over an unacknowledged word overwrites Q and sets OVR. GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN adds BUS[W] parity and PERR.
module gf180mcu_fd_sc_mcu9t5v0__bufz_rx #(
    parameter int W           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int SETTLE      = 2
) (
    input  logic         CLK,
    input  logic         RN,
    input  logic         EN,
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    input  logic [W:0]   BUS,
`else
    input  logic [W-1:0] BUS,
`endif
    input  logic         ACK,
    output logic [W-1:0] Q,
    output logic         VLD,
    output logic         OVR,
    output logic         BUSY,
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    output logic         PERR,
`endif
    inout  wire          VDD,
    inout  wire          VSS
);

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    localparam int BW = W + 1;
`else
    localparam int BW = W;
`endif
    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    logic [SYNC_STAGES-1:0]         en_sync_q, en_sync_d;
    logic [SYNC_STAGES-1:0][BW-1:0] bus_sync_q, bus_sync_d;
    logic                           en_s;
    logic [BW-1:0]                  bus_s;

    state_t        state_q, state_d;
    logic [BW-1:0] snap_q, snap_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [W-1:0]  q_q, q_d;
    logic          vld_q, vld_d;
    logic          ovr_q, ovr_d;
    logic          busy_q, busy_d;
    logic          capture;
    logic          ack_eff;

    // Supply pins carry no logic; tie them off into a named sink.
    logic unused_supply;
    assign unused_supply = VDD ^ VSS;

    assign en_s  = en_sync_q[SYNC_STAGES-1];
    assign bus_s = bus_sync_q[SYNC_STAGES-1];

    always_comb begin
        en_sync_d  = {en_sync_q[SYNC_STAGES-2:0], EN};
        bus_sync_d = {bus_sync_q[SYNC_STAGES-2:0], BUS};
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en_s) begin
                    state_d = ST_SETTLE;
                    snap_d  = bus_s;
                    cnt_d   = 4'd1;
                end
            end
            ST_SETTLE: begin
                if (!en_s) begin
                    state_d = ST_IDLE;
                end else begin
                    // Any change restarts the stability count, discarding glitches.
                    if (bus_s != snap_q) begin
                        snap_d = bus_s;
                        cnt_d  = 4'd1;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                    if (cnt_d >= SETTLE_C) begin
                        state_d = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE: begin
                if (!en_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign capture = (state_q == ST_CAPTURE);
    assign ack_eff = ACK && vld_q;

    always_comb begin
        q_d    = q_q;
        vld_d  = vld_q;
        ovr_d  = ovr_q;
        busy_d = (state_d == ST_SETTLE) || (state_d == ST_CAPTURE);
        if (ack_eff) begin
            vld_d = 1'b0;
            ovr_d = 1'b0;
        end
        if (capture) begin
            q_d   = snap_q[W-1:0];
            vld_d = 1'b1;
            // A same-edge ACK consumes the old word, so only an unacked word overruns.
            if (vld_q && !ACK) begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            en_sync_q  <= '0;
            bus_sync_q <= '0;
            state_q    <= ST_IDLE;
            snap_q     <= '0;
            cnt_q      <= '0;
            q_q        <= '0;
            vld_q      <= 1'b0;
            ovr_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            en_sync_q  <= en_sync_d;
            bus_sync_q <= bus_sync_d;
            state_q    <= state_d;
            snap_q     <= snap_d;
            cnt_q      <= cnt_d;
            q_q        <= q_d;
            vld_q      <= vld_d;
            ovr_q      <= ovr_d;
            busy_q     <= busy_d;
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (ack_eff) begin
            perr_d = 1'b0;
        end
        if (capture) begin
            perr_d = ^snap_q;
        end
    end

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign PERR = perr_q;
`endif

    assign Q    = q_q;
    assign VLD  = vld_q;
    assign OVR  = ovr_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufz_rx.sv
// Directed bench for the bufz receiver: cycle table for capture/settle/pulse cases, hand sequences for overrun, reset and parity.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufz_rx;

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    localparam int BW = 9;
`else
    localparam int BW = 8;
`endif

    logic          clk;
    logic          rn;
    logic          en;
    logic [BW-1:0] bus;
    logic          ack;
    logic [7:0]    q;
    logic          vld;
    logic          ovr;
    logic          busy;
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
    logic          perr;
`endif
    wire           vdd;
    wire           vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    int tests = 0;
    int fails = 0;

    gf180mcu_fd_sc_mcu9t5v0__bufz_rx #(.W(8), .SYNC_STAGES(2), .SETTLE(2)) dut (
        .CLK (clk),
        .RN  (rn),
        .EN  (en),
        .BUS (bus),
        .ACK (ack),
        .Q   (q),
        .VLD (vld),
        .OVR (ovr),
        .BUSY(busy),
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
        .PERR(perr),
`endif
        .VDD (vdd),
        .VSS (vss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       en;
        logic [7:0] bus;
        logic       ack;
        logic [7:0] q;
        logic       vld;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [BW-1:0] enc(input logic [7:0] d);
`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
        return {^d, d};
`else
        return d;
`endif
    endfunction

    task automatic add(input logic e, input logic [7:0] b, input logic a,
                       input logic [7:0] eq, input logic ev, input logic eb);
        vec_t v;
        v.en = e; v.bus = b; v.ack = a; v.q = eq; v.vld = ev; v.busy = eb;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] eq, input logic ev,
                             input logic eo, input logic eb);
        check({tag, "_q"},    32'(q),    32'(eq));
        check({tag, "_vld"},  32'(vld),  32'(ev));
        check({tag, "_ovr"},  32'(ovr),  32'(eo));
        check({tag, "_busy"}, 32'(busy), 32'(eb));
    endtask

    // Opens an enable window with BUS held; returns just after the capture edge (edge 5).
    task automatic window(input logic [BW-1:0] b, input logic ack_on_capture);
        en  = 1'b1;
        bus = b;
        repeat (4) @(negedge clk);
        ack = ack_on_capture;
        @(negedge clk);
        ack = 1'b0;
        en  = 1'b0;
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    initial begin
        rn  = 1'b0;
        en  = 1'b0;
        bus = '0;
        ack = 1'b0;

        // Basic capture + ACK, ACK with VLD low ignored
        add(1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 8'hA5, 0, 8'h00, 0, 0);
        add(1, 8'hA5, 0, 8'h00, 0, 1);
        add(1, 8'hA5, 0, 8'h00, 0, 1);
        add(1, 8'hA5, 0, 8'hA5, 1, 0);
        add(1, 8'hA5, 1, 8'hA5, 0, 0);
        add(0, 8'hA5, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 0, 8'hA5, 0, 0);
        add(0, 8'h00, 1, 8'hA5, 0, 0);
        add(0, 8'h00, 0, 8'hA5, 0, 0);
        // Settle restart: 0x11 seen for one synchronized cycle, then 0x22
        add(1, 8'h11, 0, 8'hA5, 0, 0);
        add(1, 8'h22, 0, 8'hA5, 0, 0);
        add(1, 8'h22, 0, 8'hA5, 0, 1);
        add(1, 8'h22, 0, 8'hA5, 0, 1);
        add(1, 8'h22, 0, 8'hA5, 0, 1);
        add(1, 8'h22, 0, 8'h22, 1, 0);
        add(0, 8'h22, 1, 8'h22, 0, 0);
        add(0, 8'h22, 0, 8'h22, 0, 0);
        add(0, 8'h22, 0, 8'h22, 0, 0);
        // One-cycle EN pulse: enters SETTLE briefly, never captures
        add(1, 8'h55, 0, 8'h22, 0, 0);
        add(0, 8'h55, 0, 8'h22, 0, 0);
        add(0, 8'h55, 0, 8'h22, 0, 1);
        add(0, 8'h55, 0, 8'h22, 0, 0);
        add(0, 8'h55, 0, 8'h22, 0, 0);
        add(0, 8'h55, 0, 8'h22, 0, 0);

        repeat (2) @(negedge clk);
        check_out("rst_low", 8'h00, 0, 0, 0);
        rn = 1'b1;
        @(negedge clk);
        check_out("rst_rel", 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            en  = tbl[i].en;
            bus = enc(tbl[i].bus);
            ack = tbl[i].ack;
            @(negedge clk);
            check_out($sformatf("row%0d", i), tbl[i].q, tbl[i].vld, 1'b0, tbl[i].busy);
        end
        ack = 1'b0;

        // Overrun and its clearing
        window(enc(8'h01), 1'b0);
        check_out("ovr_w1", 8'h01, 1, 0, 0);
        repeat (4) @(negedge clk);
        window(enc(8'h02), 1'b0);
        check_out("ovr_w2", 8'h02, 1, 1, 0);
        pulse_ack();
        check_out("ovr_ack", 8'h02, 0, 0, 0);
        repeat (4) @(negedge clk);
        window(enc(8'h03), 1'b0);
        check_out("ovr_w3", 8'h03, 1, 0, 0);
        repeat (4) @(negedge clk);
        window(enc(8'h04), 1'b1);
        check_out("ovr_ackcap", 8'h04, 1, 0, 0);
        repeat (4) @(negedge clk);

        // Reset during SETTLE with EN still high at release
        en  = 1'b1;
        bus = enc(8'h3C);
        repeat (3) @(negedge clk);
        check_out("mid_settle", 8'h04, 1, 0, 1);
        #2 rn = 1'b0;
        #1 check_out("mid_rst", 8'h00, 0, 0, 0);
        @(negedge clk);
        rn = 1'b1;
        repeat (4) @(negedge clk);
        check_out("post_rst_e4", 8'h00, 0, 0, 1);
        @(negedge clk);
        check_out("post_rst_e5", 8'h3C, 1, 0, 0);
        en = 1'b0;
        pulse_ack();
        check_out("post_rst_ack", 8'h3C, 0, 0, 0);
        repeat (4) @(negedge clk);

`ifdef GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN
        window(9'h101, 1'b0);
        check("par_good_perr", 32'(perr), 32'd0);
        check("par_good_q", 32'(q), 32'h01);
        pulse_ack();
        repeat (4) @(negedge clk);
        window(9'h001, 1'b0);
        check("par_bad_perr", 32'(perr), 32'd1);
        check("par_bad_vld", 32'(vld), 32'd1);
        pulse_ack();
        check("par_ack_perr", 32'(perr), 32'd0);
        repeat (4) @(negedge clk);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__bufz_rx.md
# gf180mcu_fd_sc_mcu9t5v0__bufz_rx

Clocked receiver for a shared tri-state bus driven by `bufz` drivers. It synchronizes the bus enable and bus data into the CLK domain and waits for the data to stay stable. It then captures one word per enable window and presents it to the local consumer with a valid/acknowledge handshake. It sits at the load end of every multi-driver bus segment built from the 9-track 5 V `bufz` cells.

## Interface
Parameters:
- `W`, 8: data width, 1..32.
- `SYNC_STAGES`, 2: synchronizer depth for EN and BUS, 2..3.
- `SETTLE`, 2: consecutive identical synchronized samples required before capture, 1..15.

Ports:
- `CLK` input 1: rising-edge clock.
- `RN` input 1: reset. Asynchronous, active-low.
- `EN` input 1: bus-drive enable. This is the same net that drives the active driver's `bufz` EN.
- `BUS` input W (W+1 with parity, see Configuration): resolved bus value.
- `ACK` input 1: consumer accepts the word currently held on Q.
- `Q` output W: captured word.
- `VLD` output 1: Q holds an unacknowledged word.
- `OVR` output 1: sticky overrun flag.
- `BUSY` output 1: FSM is in SETTLE or CAPTURE.
- `PERR` output 1: parity error on the held word. Present only with parity enabled.
- `VDD`, `VSS` inout: supply pins, no logic function.

## Operation
- EN and every BUS bit each pass through `SYNC_STAGES` flops; the outputs are en_s and bus_s.
- FSM states: IDLE, SETTLE, CAPTURE, DONE.
- IDLE:
  - Entered on reset.
  - en_s=1 → SETTLE. The snapshot is loaded from bus_s and the stable count is set to 1.
- SETTLE:
  - en_s=0 → IDLE. Nothing is captured.
  - bus_s differs from the snapshot → the snapshot is reloaded and the count resets to 1.
  - bus_s equals the snapshot → the count increments.
  - When the count reaches `SETTLE` → CAPTURE. With SETTLE=1, the next edge goes to CAPTURE.
- CAPTURE (one cycle): Q ← snapshot, VLD ← 1 → DONE.
- DONE:
  - Waits for en_s=0 → IDLE.
  - Only one word is captured per enable window. Later data changes while EN stays high are ignored.
- Handshake:
  - ACK while VLD=1 clears VLD on the same edge.
  - ACK while VLD=0 is ignored.
  - Q holds its value until the next capture; it is never cleared except by reset.
- Overrun:
  - A capture while VLD=1 and ACK=0 overwrites Q, keeps VLD=1 and sets OVR.
  - A capture in the same cycle as ACK loads the new word, keeps VLD=1 and does not set OVR.
  - OVR clears on an ACK edge, unless a new overrun occurs on that same edge.
- BUSY=1 exactly in SETTLE and CAPTURE.
- Reset asserted at any point clears all state immediately. If EN is still high after RN releases, the receiver performs a full synchronize-and-settle and captures a new word.

## Timing
- All outputs are registered.
- Reset values: Q=0, VLD=0, OVR=0, BUSY=0, PERR=0. All synchronizer flops are 0 and the FSM is in IDLE.
- Latency:
  - EN and BUS change before edge 1 and are then held stable.
  - VLD and Q update on edge `SYNC_STAGES + SETTLE + 1`. Defaults: edge 5.
- BUS must be stable for at least `SETTLE` cycles after synchronization. Shorter pulses are discarded by the count restart.
- Back-to-back enable windows: EN low for at least `SYNC_STAGES`+1 cycles is guaranteed to be seen. A shorter low pulse may be missed, and the next window then produces no capture.
- ACK to VLD low: 1 edge.

## Configuration
- `GF180MCU_FD_SC_MCU9T5V0_BUFZ_RX_PARITY_EN`
  - Defined:
    - BUS is W+1 bits and BUS[W] is even parity over BUS[W-1:0].
    - Q excludes the parity bit.
    - PERR loads together with Q at CAPTURE: 1 if the parity of the snapshot is odd.
    - PERR clears with VLD on ACK.
  - Undefined: BUS is W bits, the PERR port does not exist, and no parity logic is built.

## Test plan
- Reset check: RN low, then released while EN=0 → Q=0x00, VLD=0, OVR=0, BUSY=0.
- Basic capture: EN=1 with BUS=0xA5 held (defaults) → VLD=1 and Q=0xA5 on edge 5. ACK for one cycle → VLD=0 next edge, Q stays 0xA5.
- Settle restart: EN=1, BUS=0x11 for 1 synchronized cycle, then 0x22 held → capture 0x22 only, VLD rises one edge later than the basic case. EN pulse of 1 cycle → no capture.
- Overrun: capture 0x01 with no ACK, EN low for 4 cycles, then capture 0x02 → Q=0x02, VLD=1, OVR=1. ACK → VLD=0, OVR=0. Repeat with ACK on the capture edge → OVR stays 0.
- Reset mid-operation: RN pulsed low during SETTLE → outputs reset immediately. EN is still high at release with BUS=0x3C → captured at edge 5 after release.
- Parity (macro defined): BUS={1'b1, 0x01} → PERR=0. BUS={1'b0, 0x01} → PERR=1 with VLD. ACK → PERR=0.
